// File: rtl/kalman_pkg.sv
// Shared types and widths for the Kalman update sequencer and its dt timer.
package kalman_pkg;

  localparam int GYRO_W       = 48;
  localparam int ANGLE_W      = 16;
  localparam int DT_W         = 8;
  localparam int DEF_TICK_DIV = 1000;
  localparam int DEF_SETTLE   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_PITCH,
    S_YAW,
    S_ROLL,
    S_DONE
  } state_t;

endpackage

// File: rtl/kalman_dt_timer.sv
// Free-running prescaler feeding a saturating count of dt ticks since the last clear.
module kalman_dt_timer
  import kalman_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            clear,
  output logic [DT_W-1:0] dt_cnt
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] r_pre;
  logic          w_wrap;

  assign w_wrap = (r_pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pre <= '0;
    end else if (w_wrap) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Clear has priority: a tick landing on the clear cycle is dropped.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dt_cnt <= '0;
    end else if (clear) begin
      dt_cnt <= '0;
    end else if (w_wrap && (dt_cnt != {DT_W{1'b1}})) begin
      dt_cnt <= dt_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/kalman_sequencer.sv
// Collects a gyro/accelerometer sample pair and strobes the filter through
// load, settle, pitch, yaw and roll steps, reporting elapsed dt ticks.
module kalman_sequencer
  import kalman_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int SETTLE   = DEF_SETTLE
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               gyro_valid,
  input  logic [GYRO_W-1:0]  gyro_in,
  input  logic               acc_valid,
  input  logic [ANGLE_W-1:0] acc_pitch_in,
  input  logic [ANGLE_W-1:0] acc_yaw_in,
  input  logic [ANGLE_W-1:0] acc_roll_in,
  input  logic               clr_overrun,
  output logic [GYRO_W-1:0]  gyro_data,
  output logic [DT_W-1:0]    dt_out,
  output logic [ANGLE_W-1:0] new_angle_out,
  output logic [ANGLE_W-1:0] yaw_data,
  output logic [ANGLE_W-1:0] roll_data,
  output logic               load_gyro,
  output logic               pitch_en,
  output logic               yaw_en,
  output logic               roll_en,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t          r_state;
  state_t          w_next;
  logic [SW-1:0]   r_settle_cnt;
  logic            r_gyro_pend;
  logic            r_acc_pend;
  logic            w_idle;
  logic            w_start;
  logic            w_settle_last;
  logic [DT_W-1:0] w_dt_cnt;

  assign w_idle        = (r_state == S_IDLE);
  assign w_start       = w_idle && r_gyro_pend && r_acc_pend;
  assign w_settle_last = (r_settle_cnt == SW'(SETTLE - 1));

  kalman_dt_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_dt_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (w_start),
    .dt_cnt (w_dt_cnt)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    load_gyro = 1'b0;
    pitch_en  = 1'b0;
    yaw_en    = 1'b0;
    roll_en   = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (r_gyro_pend && r_acc_pend) w_next = S_LOAD;
      end
      S_LOAD: begin
        load_gyro = 1'b1;
        w_next    = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_settle_last) w_next = S_PITCH;
      end
      S_PITCH: begin
        pitch_en = 1'b1;
        w_next   = S_YAW;
      end
      S_YAW: begin
        yaw_en = 1'b1;
        w_next = S_ROLL;
      end
      S_ROLL: begin
        roll_en = 1'b1;
        w_next  = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_settle_cnt <= '0;
    end else if (r_state == S_SETTLE) begin
      r_settle_cnt <= r_settle_cnt + 1'b1;
    end else begin
      r_settle_cnt <= '0;
    end
  end

  // Samples are only accepted in IDLE; entering LOAD consumes both pend flags,
  // so a capture on the launch cycle itself is the one that gets loaded.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gyro_data     <= '0;
      r_gyro_pend   <= 1'b0;
      new_angle_out <= '0;
      yaw_data      <= '0;
      roll_data     <= '0;
      r_acc_pend    <= 1'b0;
      dt_out        <= '0;
    end else begin
      if (w_idle && gyro_valid) begin
        gyro_data   <= gyro_in;
        r_gyro_pend <= 1'b1;
      end
      if (w_idle && acc_valid) begin
        new_angle_out <= acc_pitch_in;
        yaw_data      <= acc_yaw_in;
        roll_data     <= acc_roll_in;
        r_acc_pend    <= 1'b1;
      end
      if (w_start) begin
        r_gyro_pend <= 1'b0;
        r_acc_pend  <= 1'b0;
        dt_out      <= w_dt_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overrun <= 1'b0;
    end else if (gyro_valid && !w_idle) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kalman_sequencer.sv
// Scoreboard bench: a transaction-level model predicts each update and the
// per-cycle busy/overrun flags; a negedge monitor checks the DUT against them.
module tb_kalman_sequencer;

  localparam int TD = 4;
  localparam int S  = 2;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        gyro_valid = 1'b0;
  logic [47:0] gyro_in = '0;
  logic        acc_valid = 1'b0;
  logic [15:0] acc_pitch_in = '0;
  logic [15:0] acc_yaw_in = '0;
  logic [15:0] acc_roll_in = '0;
  logic        clr_overrun = 1'b0;
  logic [47:0] gyro_data;
  logic [7:0]  dt_out;
  logic [15:0] new_angle_out, yaw_data, roll_data;
  logic        load_gyro, pitch_en, yaw_en, roll_en, busy, done, overrun;

  kalman_sequencer #(.TICK_DIV(TD), .SETTLE(S)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .gyro_valid    (gyro_valid),
    .gyro_in       (gyro_in),
    .acc_valid     (acc_valid),
    .acc_pitch_in  (acc_pitch_in),
    .acc_yaw_in    (acc_yaw_in),
    .acc_roll_in   (acc_roll_in),
    .clr_overrun   (clr_overrun),
    .gyro_data     (gyro_data),
    .dt_out        (dt_out),
    .new_angle_out (new_angle_out),
    .yaw_data      (yaw_data),
    .roll_data     (roll_data),
    .load_gyro     (load_gyro),
    .pitch_en      (pitch_en),
    .yaw_en        (yaw_en),
    .roll_en       (roll_en),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  // Cycle index = rising edges seen since reset release.
  int cyc;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          L;
    logic [47:0] g;
    logic [15:0] p;
    logic [15:0] y;
    logic [15:0] r;
    logic [7:0]  dt;
  } upd_t;

  upd_t sbq[$];
  upd_t cur;
  bit   have = 0;

  bit          m_gp, m_ap, m_ovr;
  logic [47:0] m_g;
  logic [15:0] m_p, m_y, m_r;
  int          m_L = -100, m_D = -100, m_P = 0;
  bit          exp_busy = 0, exp_ovr = 0, nx_busy = 0, nx_ovr = 0;

  // Ticks fall on rising edges k (k>=1) with k % TD == 0; dt counts those
  // strictly between the previous launch edge and this one, capped at 255.
  function automatic logic [7:0] dt_model(input int p, input int l);
    int n;
    n = (l - 1) / TD - p / TD;
    if (n > 255) n = 255;
    return 8'(n);
  endfunction

  task automatic model_reset();
    m_gp = 0; m_ap = 0; m_ovr = 0;
    m_g = '0; m_p = '0; m_y = '0; m_r = '0;
    m_L = -100; m_D = -100; m_P = 0;
    exp_busy = 0; exp_ovr = 0; nx_busy = 0; nx_ovr = 0;
    sbq.delete();
    have = 0;
  endtask

  task automatic step(input bit gv, input logic [47:0] gin, input bit av,
                      input logic [15:0] ap, input logic [15:0] ay,
                      input logic [15:0] ar, input bit clr);
    bit busy_c, start, set;
    @(posedge clk);
    #1;
    exp_busy = nx_busy;
    exp_ovr  = nx_ovr;
    gyro_valid = gv; gyro_in = gin; acc_valid = av;
    acc_pitch_in = ap; acc_yaw_in = ay; acc_roll_in = ar; clr_overrun = clr;
    busy_c = (cyc >= m_L) && (cyc <= m_D);
    start  = !busy_c && m_gp && m_ap;
    set    = 0;
    if (!busy_c) begin
      if (gv) begin m_g = gin; m_gp = 1; end
      if (av) begin m_p = ap; m_y = ay; m_r = ar; m_ap = 1; end
    end else if (gv) begin
      set = 1;
    end
    if (start) begin
      m_L = cyc + 1;
      m_D = m_L + 4 + S;
      m_gp = 0; m_ap = 0;
      sbq.push_back('{m_L, m_g, m_p, m_y, m_r, dt_model(m_P, m_L)});
      m_P = m_L;
    end
    m_ovr   = set | (m_ovr & !clr);
    nx_ovr  = m_ovr;
    nx_busy = (cyc + 1 >= m_L) && (cyc + 1 <= m_D);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, 0, '0, '0, '0, 0);
  endtask

  task automatic run_until(input int t);
    while (cyc + 1 < t) step(0, '0, 0, '0, '0, '0, 0);
  endtask

  // Issue a simultaneous pair, then one more cycle so the model has launched.
  task automatic go(input logic [47:0] g, input logic [15:0] p, input logic [15:0] y,
                    input logic [15:0] r);
    step(1, g, 1, p, y, r, 0);
    idle(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load_gyro"}, load_gyro, 0);
    check({tag, "_pitch_en"}, pitch_en, 0);
    check({tag, "_yaw_en"}, yaw_en, 0);
    check({tag, "_roll_en"}, roll_en, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_gyro_data"}, gyro_data, 0);
    check({tag, "_dt_out"}, dt_out, 0);
    check({tag, "_pitch_data"}, new_angle_out, 0);
    check({tag, "_yaw_data"}, yaw_data, 0);
    check({tag, "_roll_data"}, roll_data, 0);
  endtask

  always @(negedge clk) begin : monitor
    int ns;
    if (n_rst) begin
      check("busy", busy, exp_busy);
      check("overrun", overrun, exp_ovr);
      ns = int'(load_gyro) + int'(pitch_en) + int'(yaw_en) + int'(roll_en) + int'(done);
      check("one_strobe", ns <= 1, 1);
      if (!have && sbq.size() > 0 && cyc >= sbq[0].L) begin
        cur  = sbq.pop_front();
        have = 1;
      end
      if (have) begin
        check("load_gyro", load_gyro, cyc == cur.L);
        check("pitch_en", pitch_en, cyc == cur.L + 1 + S);
        check("yaw_en", yaw_en, cyc == cur.L + 2 + S);
        check("roll_en", roll_en, cyc == cur.L + 3 + S);
        check("done", done, cyc == cur.L + 4 + S);
        check("gyro_data", gyro_data, cur.g);
        check("pitch_data", new_angle_out, cur.p);
        check("yaw_data", yaw_data, cur.y);
        check("roll_data", roll_data, cur.r);
        check("dt_out", dt_out, cur.dt);
        if (cyc >= cur.L + 4 + S) have = 0;
      end else begin
        check("idle_strobes", ns, 0);
      end
    end
  end

  initial begin
    int c;
    model_reset();
    #2;
    check_all_zero("reset");
    #20;
    @(negedge clk);
    #2 n_rst = 1'b1;

    go(48'h0003_0002_0001, 16'h0aaa, 16'h0bbb, 16'h0ccc);
    c = cyc - 1;
    idle(12);

    run_until(c + 40);
    go({$urandom, 16'h5a5a}, 16'($urandom), 16'($urandom), 16'($urandom));
    idle(12);
    idle(2000);
    go({$urandom, 16'h0f0f}, 16'($urandom), 16'($urandom), 16'($urandom));
    idle(12);

    go(48'h1111_2222_3333, 16'h0101, 16'h0202, 16'h0303);
    run_until(m_L + 2 + S);
    step(1, 48'hdead_beef_cafe, 0, '0, '0, '0, 0);
    idle(2);
    step(0, '0, 0, '0, '0, '0, 1);
    idle(2);
    go(48'h4444_5555_6666, 16'h0404, 16'h0505, 16'h0606);
    run_until(m_L + 1);
    step(1, 48'h7777_8888_9999, 0, '0, '0, '0, 1);
    idle(12);
    step(0, '0, 0, '0, '0, '0, 1);
    idle(3);

    step(1, 48'habcd_ef01_2345, 0, '0, '0, '0, 0);
    c = cyc;
    run_until(c + 10);
    step(0, '0, 1, 16'h0777, 16'h0888, 16'h0999, 0);
    idle(1);
    run_until(m_L + 1);
    step(0, '0, 1, 16'h1234, 16'h5678, 16'h9abc, 0);
    idle(12);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 7) == 0, {$urandom, 16'($urandom)},
           $urandom_range(0, 7) == 0, 16'($urandom), 16'($urandom), 16'($urandom),
           $urandom_range(0, 15) == 0);
    end
    idle(15);

    go(48'h0aaa_0bbb_0ccc, 16'h1357, 16'h2468, 16'h369c);
    run_until(m_L + 2 + S);
    idle(1);
    #2;
    check("yaw_before_reset", yaw_en, 1);
    n_rst = 1'b0;
    gyro_valid = 0; acc_valid = 0; clr_overrun = 0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    #2 n_rst = 1'b1;
    idle(40);
    go(48'h0102_0304_0506, 16'h0011, 16'h0022, 16'h0033);
    idle(15);

    check("scoreboard_drained", sbq.size(), 0);
    check("no_open_update", have, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/kalman_sequencer.md
KALMAN_SEQUENCER -- requirements
Module: kalman_sequencer

Interface
REQ-001 Parameter TICK_DIV, 1000, clk cycles per dt tick (>=2).
REQ-002 Parameter SETTLE, 2, idle cycles between load_gyro and pitch_en (>=1).
REQ-003 clk  in  1  clock, rising-edge.
REQ-004 n_rst  in  1  reset n_rst, asynchronous, active-low; clock clk.
REQ-005 gyro_valid  in  1  one-cycle pulse, gyro_in valid.
REQ-006 gyro_in  in  48  [15:0] roll, [31:16] pitch, [47:32] yaw rate.
REQ-007 acc_valid  in  1  one-cycle pulse, accelerometer angles valid.
REQ-008 acc_pitch_in / acc_yaw_in / acc_roll_in  in  16 each  accelerometer angles.
REQ-009 clr_overrun  in  1  clears overrun.
REQ-010 gyro_data  out  48  held gyro sample, to filter.
REQ-011 dt_out  out  8  ticks since previous update, to filter.
REQ-012 new_angle_out / yaw_data / roll_data  out  16 each  held accelerometer pitch/yaw/roll.
REQ-013 load_gyro, pitch_en, yaw_en, roll_en  out  1 each  filter strobes.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse, update complete.
REQ-016 overrun  out  1  sticky, gyro sample dropped.

Function
REQ-017 FSM states IDLE, LOAD, SETTLE, PITCH, YAW, ROLL, DONE; all strobes Moore-decoded from state.
REQ-018 gyro_valid in IDLE: gyro_in captured into gyro_data, gyro_pend set; repeat in IDLE overwrites, no overrun.
REQ-019 acc_valid in IDLE: three angles captured, acc_pend set; repeat overwrites.
REQ-020 gyro_valid while busy: sample discarded, gyro_data unchanged, overrun set next edge.
REQ-021 acc_valid while busy: discarded silently; held angles stable from LOAD through DONE.
REQ-022 IDLE -> LOAD when gyro_pend and acc_pend both set (registered); both flags clear on entering LOAD.
REQ-023 LOAD one cycle, load_gyro=1; LOAD -> SETTLE.
REQ-024 SETTLE lasts exactly SETTLE cycles, no strobes; then PITCH.
REQ-025 PITCH, YAW, ROLL one cycle each with pitch_en, yaw_en, roll_en=1 respectively; at most one strobe high per cycle.
REQ-026 ROLL -> DONE (done=1, one cycle) -> IDLE.
REQ-027 Latency: valid pulses in cycle 0 -> load_gyro cycle 2, pitch_en cycle 3+SETTLE, yaw_en 4+SETTLE, roll_en 5+SETTLE, done 6+SETTLE.
REQ-028 Simultaneous gyro_valid and acc_valid in IDLE: both captured, same latency as REQ-027.
REQ-029 Prescaler counts 0..TICK_DIV-1 free-running; wrap produces one tick.
REQ-030 dt_cnt increments per tick, saturates at 255.
REQ-031 On LOAD entry: dt_out <= dt_cnt, dt_cnt <= 0 (tick in same cycle lost); prescaler not reset.
REQ-032 dt_out held constant between LOAD cycles.
REQ-033 overrun clears on clr_overrun; set wins over clear in same cycle.

Reset
REQ-034 n_rst low: state IDLE, both pend flags 0, prescaler 0, dt_cnt 0, all outputs 0, immediately.
REQ-035 Reset mid-update aborts sequence; no further strobes until new pair of valids after release.

Structure
REQ-036 Package kalman_pkg holds state enum, GYRO_W=48, ANGLE_W=16, DT_W=8, default TICK_DIV and SETTLE.
REQ-037 Sub-module kalman_dt_timer holds prescaler and saturating dt_cnt, inputs clear, output dt_cnt.

Verification (TICK_DIV=4, SETTLE=2)
REQ-038 gyro_valid, acc_valid same cycle 0, gyro_in=48'h0003_0002_0001 -> load_gyro cycle 2, pitch_en 5, yaw_en 6, roll_en 7, done 8, gyro_data=48'h0003_0002_0001.
REQ-039 Updates 40 cycles apart -> second dt_out=10; no update for 2000 cycles -> dt_out=255.
REQ-040 gyro_valid during YAW -> gyro_data unchanged, overrun=1 next cycle; clr_overrun -> 0; clr_overrun with new overrun same cycle -> stays 1.
REQ-041 gyro_valid cycle 0, acc_valid cycle 10 -> load_gyro cycle 12; acc_valid during SETTLE with acc_pitch_in=16'h1234 -> new_angle_out unchanged.
REQ-042 n_rst low during YAW -> yaw_en, busy, outputs 0 immediately; after release no strobes without new valids.
